// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash command layer: opcodes, op encoding,
// status-register bit positions and the sequencer state set.
package spi_flash_pkg;

    localparam logic [7:0] CMD_WREN      = 8'h06;
    localparam logic [7:0] CMD_WRDI      = 8'h04;
    localparam logic [7:0] CMD_RDID      = 8'h9F;
    localparam logic [7:0] CMD_RDSR      = 8'h05;
    localparam logic [7:0] CMD_WRSR      = 8'h01;
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_PP        = 8'h02;
    localparam logic [7:0] CMD_SE        = 8'hD8;
    localparam logic [7:0] CMD_BE        = 8'hC7;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_READ_ID = 2'd3
    } op_e;

    localparam int unsigned SR_WIP = 0;
    localparam int unsigned SR_WEL = 1;

    localparam logic [8:0] MAX_LEN = 9'd256;

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_WREN, S_WREN_W, S_OP, S_OP_W,
        S_GAP, S_POLL, S_POLL_W, S_POLL_DLY, S_DONE
    } state_e;

    // Main opcode issued in the OP state for a given request type
    function automatic logic [7:0] op_opcode(input op_e op);
        case (op)
            OP_READ:    return CMD_READ;
            OP_PROGRAM: return CMD_PP;
            OP_ERASE:   return CMD_SE;
            default:    return CMD_RDID;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_wait_cnt.sv
// 16-bit load/decrement timer. Loaded with N, done is high on the last of N
// cycles (a load of 0 or 1 gives a single cycle), so a wait state entered
// together with the load lasts exactly N cycles.
module spi_flash_wait_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done
);

    logic [15:0] cnt;

    // Load has priority; otherwise count down and stop at zero
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 16'd1;
    end

    assign done = (cnt <= 16'd1);

endmodule

// File: rtl/spi_flash_op_seq.sv
// High-level flash operation sequencer: turns one request into
// WREN / op / RDSR-poll command sequences for spi_flash_cmd, with a
// chip-select gap after every command.
module spi_flash_op_seq
    import spi_flash_pkg::*;
#(
    parameter int unsigned CS_GAP   = 16,
    parameter int unsigned POLL_GAP = 1000,
    parameter int unsigned POLL_MAX = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_op_valid,
    input  logic [1:0]  i_op,
    input  logic [23:0] i_op_addr,
    input  logic [8:0]  i_op_len,
    output logic        o_op_ready,
    output logic        o_op_done,
    output logic        o_op_err,
    output logic [7:0]  o_status,
    output logic        o_wr_req,
    input  logic [7:0]  i_wr_data,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ack,
    output logic [23:0] o_addr,
    output logic [8:0]  o_byte_size,
    input  logic        i_data_req,
    output logic [7:0]  o_data_in,
    input  logic [7:0]  i_data_out,
    input  logic        i_data_valid
);

    state_e      state, next;
    state_e      gap_from;
    op_e         op_q;
    logic [23:0] addr_q;
    logic [8:0]  len_q;
    logic [15:0] poll_cnt;
    logic        err_q;
    logic        tmr_load, tmr_done;
    logic [15:0] tmr_val;
    logic        accept, len_bad, is_rd, in_wait, timeout;

    assign accept  = (state == S_IDLE) && i_op_valid;
    assign len_bad = ((len_q == '0) || (len_q > MAX_LEN)) && (op_q != OP_ERASE);
    assign is_rd   = (op_q == OP_READ) || (op_q == OP_READ_ID);
    assign in_wait = (state == S_WREN_W) || (state == S_OP_W) || (state == S_POLL_W);
    assign timeout = o_status[SR_WIP] && (poll_cnt == 16'(POLL_MAX));

    spi_flash_wait_cnt u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next;
    end

    // Next-state and timer load; GAP resumes according to the command it follows
    always_comb begin
        next     = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE:   if (i_op_valid) next = S_CHK;
            S_CHK: begin
                if (len_bad)    next = S_DONE;
                else if (is_rd) next = S_OP;
                else            next = S_WREN;
            end
            S_WREN:   next = S_WREN_W;
            S_OP:     next = S_OP_W;
            S_POLL:   next = S_POLL_W;
            S_WREN_W, S_OP_W, S_POLL_W: begin
                if (i_cmd_ack) begin
                    next     = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = 16'(CS_GAP);
                end
            end
            S_GAP: begin
                if (tmr_done) begin
                    case (gap_from)
                        S_WREN_W: next = S_OP;
                        S_OP_W:   next = is_rd ? S_DONE : S_POLL;
                        S_POLL_W: begin
                            if (!o_status[SR_WIP] || timeout) begin
                                next = S_DONE;
                            end else begin
                                next     = S_POLL_DLY;
                                tmr_load = 1'b1;
                                tmr_val  = 16'(POLL_GAP);
                            end
                        end
                        default:  next = S_IDLE;
                    endcase
                end
            end
            S_POLL_DLY: if (tmr_done) next = S_POLL;
            S_DONE:     next = S_IDLE;
            default:    next = S_IDLE;
        endcase
    end

    // Request latch, poll counter, error flag, status capture and read mirror
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OP_READ;
            addr_q     <= '0;
            len_q      <= '0;
            poll_cnt   <= '0;
            err_q      <= 1'b0;
            gap_from   <= S_IDLE;
            o_status   <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= op_e'(i_op);
                addr_q   <= i_op_addr;
                len_q    <= i_op_len;
                poll_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (state == S_CHK && len_bad)
                err_q <= 1'b1;
            if (state == S_GAP && tmr_done && gap_from == S_POLL_W && timeout)
                err_q <= 1'b1;
            if (state == S_POLL)
                poll_cnt <= poll_cnt + 16'd1;
            if (in_wait && i_cmd_ack)
                gap_from <= state;
            if (state == S_POLL_W && i_data_valid)
                o_status <= i_data_out;
            o_rd_valid <= (state == S_OP_W) && is_rd && i_data_valid;
            if ((state == S_OP_W) && is_rd && i_data_valid)
                o_rd_data <= i_data_out;
        end
    end

    // Command port and handshake decode; opcode held through the _W state
    always_comb begin
        o_op_ready  = (state == S_IDLE);
        o_op_done   = (state == S_DONE);
        o_op_err    = (state == S_DONE) && err_q;
        o_cmd_valid = (state == S_WREN) || (state == S_OP) || (state == S_POLL);
        o_addr      = addr_q;
        o_cmd       = '0;
        o_byte_size = '0;
        case (state)
            S_WREN, S_WREN_W: o_cmd = CMD_WREN;
            S_OP, S_OP_W: begin
                o_cmd       = op_opcode(op_q);
                o_byte_size = (op_q == OP_ERASE) ? 9'd0 : len_q;
            end
            S_POLL, S_POLL_W: begin
                o_cmd       = CMD_RDSR;
                o_byte_size = 9'd1;
            end
            default: ;
        endcase
        o_wr_req  = (state == S_OP_W) && (op_q == OP_PROGRAM) && i_data_req;
        o_data_in = ((state == S_OP_W) && (op_q == OP_PROGRAM)) ? i_wr_data : 8'h00;
    end

endmodule

// File: tb/tb_spi_flash_op_seq.sv
// Self-checking bench: a behavioural spi_flash_cmd/flash responder plus a
// per-request reference model of the expected command sequence and results.
module tb_spi_flash_op_seq;
    import spi_flash_pkg::*;

    localparam int CS_GAP   = 3;
    localparam int POLL_GAP = 20;
    localparam int POLL_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_op_valid = 1'b0;
    logic [1:0]  i_op = '0;
    logic [23:0] i_op_addr = '0;
    logic [8:0]  i_op_len = '0;
    logic        o_op_ready, o_op_done, o_op_err;
    logic [7:0]  o_status;
    logic        o_wr_req;
    logic [7:0]  i_wr_data = '0;
    logic [7:0]  o_rd_data;
    logic        o_rd_valid;
    logic [7:0]  o_cmd;
    logic        o_cmd_valid;
    logic        i_cmd_ack = 1'b0;
    logic [23:0] o_addr;
    logic [8:0]  o_byte_size;
    logic        i_data_req = 1'b0;
    logic [7:0]  o_data_in;
    logic [7:0]  i_data_out = '0;
    logic        i_data_valid = 1'b0;

    spi_flash_op_seq #(.CS_GAP(CS_GAP), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_op_valid(i_op_valid), .i_op(i_op), .i_op_addr(i_op_addr), .i_op_len(i_op_len),
        .o_op_ready(o_op_ready), .o_op_done(o_op_done), .o_op_err(o_op_err),
        .o_status(o_status), .o_wr_req(o_wr_req), .i_wr_data(i_wr_data),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .i_cmd_ack(i_cmd_ack),
        .o_addr(o_addr), .o_byte_size(o_byte_size),
        .i_data_req(i_data_req), .o_data_in(o_data_in),
        .i_data_out(i_data_out), .i_data_valid(i_data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flash content model: reads return A0 + low address byte; ID is fixed
    function automatic logic [7:0] rd_byte(input logic [23:0] a);
        return 8'hA0 + a[7:0];
    endfunction
    function automatic logic [7:0] id_byte(input int i);
        case (i % 3)
            0:       return 8'hEF;
            1:       return 8'h40;
            default: return 8'h18;
        endcase
    endfunction

    // User-side program byte source: next byte on the cycle after each request
    logic [7:0] prog_data [256];
    int wr_idx = 0;
    always @(posedge clk) begin
        if (o_wr_req) begin
            i_wr_data <= prog_data[wr_idx % 256];
            wr_idx    <= wr_idx + 1;
        end
    end

    // Output monitor
    typedef struct { int cyc; logic err; } done_t;
    done_t      done_q[$];
    logic [7:0] rd_q[$];
    int         wr_seen = 0;
    always @(negedge clk) begin
        if (o_op_done)  done_q.push_back('{cyc, o_op_err});
        if (o_rd_valid) rd_q.push_back(o_rd_data);
        if (o_wr_req)   wr_seen <= wr_seen + 1;
    end

    // Command responder standing in for spi_flash_cmd and the flash
    typedef struct { logic [7:0] opc; logic [23:0] addr; logic [8:0] size; int vcyc; int acyc; } cmd_t;
    cmd_t       cmd_log[$];
    logic [7:0] pp_cap[$];
    int         op_start_cmd = 0;
    int         busy_n = 0;
    int         last_ack = -1000;
    logic [7:0] cur_opc;
    logic       hold_ok;

    task automatic tick();
        @(negedge clk);
        if (o_cmd !== cur_opc || o_cmd_valid) hold_ok = 1'b0;
    endtask

    initial begin
        cmd_t c;
        int   nr;
        forever begin
            @(negedge clk);
            if (rst_n && o_cmd_valid) begin
                c.opc = o_cmd; c.addr = o_addr; c.size = o_byte_size;
                c.vcyc = cyc; c.acyc = 0;
                check("cs_gap", 32'(cyc - last_ack >= CS_GAP + 1), 32'd1);
                cur_opc = c.opc;
                hold_ok = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                if (c.opc == CMD_READ || c.opc == CMD_RDID) begin
                    for (int i = 0; i < int'(c.size); i++) begin
                        i_data_valid = 1'b1;
                        i_data_out = (c.opc == CMD_READ) ? rd_byte(c.addr + 24'(i)) : id_byte(i);
                        tick();
                        i_data_valid = 1'b0;
                        repeat ($urandom_range(0, 2)) tick();
                    end
                end else if (c.opc == CMD_PP) begin
                    for (int i = 0; i < int'(c.size); i++) begin
                        i_data_req = 1'b1;
                        tick();
                        i_data_req = 1'b0;
                        tick();
                        pp_cap.push_back(o_data_in);
                        repeat ($urandom_range(0, 1)) tick();
                    end
                end else if (c.opc == CMD_RDSR) begin
                    nr = 0;
                    for (int i = op_start_cmd; i < cmd_log.size(); i++)
                        if (cmd_log[i].opc == CMD_RDSR) nr++;
                    i_data_valid = 1'b1;
                    i_data_out = (nr < busy_n) ? 8'h01 : 8'h00;
                    tick();
                    i_data_valid = 1'b0;
                    tick();
                end
                i_cmd_ack = 1'b1;
                c.acyc = cyc;
                @(negedge clk);
                i_cmd_ack = 1'b0;
                last_ack = c.acyc;
                check("cmd_hold", 32'(hold_ok), 32'd1);
                cmd_log.push_back(c);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len,
                         output int c0);
        int t = 0;
        while (!o_op_ready && t < 200) begin @(negedge clk); t++; end
        check("ready_before_req", 32'(o_op_ready), 32'd1);
        i_op_valid = 1'b1; i_op = op; i_op_addr = addr; i_op_len = len;
        c0 = cyc;
        @(negedge clk);
        i_op_valid = 1'b0;
        i_op = 2'($urandom); i_op_addr = 24'($urandom); i_op_len = 9'($urandom);
    endtask

    logic [7:0] model_status = 8'h00;

    task automatic run_op(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len,
                          input int busy);
        int cs, ds, rs, ws, ps, wi, c0, t, n_poll, pidx, prev_ack;
        logic rej, is_wr, exp_err;
        logic [7:0] exp_ops[$];
        cs = cmd_log.size(); ds = done_q.size(); rs = rd_q.size();
        ws = wr_seen; ps = pp_cap.size(); wi = wr_idx;
        op_start_cmd = cs;
        busy_n = busy;
        issue(op, addr, len, c0);
        t = 0;
        while (done_q.size() == ds && t < 20000) begin @(negedge clk); t++; end
        check("done_seen", 32'(done_q.size() > ds), 32'd1);
        if (done_q.size() == ds) return;
        repeat (3) @(negedge clk);

        rej    = ((len == 0) || (len > 256)) && (op != OP_ERASE);
        is_wr  = (op == OP_PROGRAM) || (op == OP_ERASE);
        n_poll = (rej || !is_wr) ? 0 : ((busy >= POLL_MAX) ? POLL_MAX : busy + 1);
        exp_err = rej || (is_wr && busy >= POLL_MAX);
        if (!rej) begin
            if (is_wr) exp_ops.push_back(CMD_WREN);
            case (op)
                OP_READ:    exp_ops.push_back(CMD_READ);
                OP_PROGRAM: exp_ops.push_back(CMD_PP);
                OP_ERASE:   exp_ops.push_back(CMD_SE);
                default:    exp_ops.push_back(CMD_RDID);
            endcase
            for (int i = 0; i < n_poll; i++) exp_ops.push_back(CMD_RDSR);
            if (is_wr) model_status = (busy >= POLL_MAX) ? 8'h01 : 8'h00;
        end

        check("done_count", 32'(done_q.size() - ds), 32'd1);
        check("done_err", 32'(done_q[ds].err), 32'(exp_err));
        check("status", 32'(o_status), 32'(model_status));
        check("cmd_count", 32'(cmd_log.size() - cs), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && cs + i < cmd_log.size(); i++)
            check("cmd_opcode", 32'(cmd_log[cs + i].opc), 32'(exp_ops[i]));
        if (rej) begin
            check("rej_done_latency", 32'(done_q[ds].cyc - c0), 32'd2);
        end else if (cmd_log.size() - cs == exp_ops.size()) begin
            check("first_cmd_latency", 32'(cmd_log[cs].vcyc - c0), 32'd2);
            pidx = cs + (is_wr ? 1 : 0);
            check("op_addr", 32'(cmd_log[pidx].addr), 32'(addr));
            if (op != OP_ERASE) check("op_size", 32'(cmd_log[pidx].size), 32'(len));
            prev_ack = -1;
            for (int i = pidx + 1; i < cmd_log.size(); i++) begin
                if (prev_ack >= 0)
                    check("poll_gap", 32'(cmd_log[i].vcyc - prev_ack >= POLL_GAP), 32'd1);
                prev_ack = cmd_log[i].acyc;
            end
            if (is_wr)
                check("done_after_gap", 32'(done_q[ds].cyc - cmd_log[cmd_log.size() - 1].acyc),
                      32'(CS_GAP + 1));
        end
        if (!rej && (op == OP_READ || op == OP_READ_ID)) begin
            check("rd_count", 32'(rd_q.size() - rs), 32'(len));
            for (int i = 0; i < int'(len) && rs + i < rd_q.size(); i++)
                check("rd_data", 32'(rd_q[rs + i]),
                      32'((op == OP_READ) ? rd_byte(addr + 24'(i)) : id_byte(i)));
        end else begin
            check("rd_none", 32'(rd_q.size() - rs), 32'd0);
        end
        if (!rej && op == OP_PROGRAM) begin
            check("wr_req_count", 32'(wr_seen - ws), 32'(len));
            check("pp_count", 32'(pp_cap.size() - ps), 32'(len));
            for (int i = 0; i < int'(len) && ps + i < pp_cap.size(); i++)
                check("pp_data", 32'(pp_cap[ps + i]), 32'(prog_data[(wi + i) % 256]));
        end else begin
            check("wr_req_none", 32'(wr_seen - ws), 32'd0);
        end
    endtask

    initial begin
        int c0, t, cs, ds, nr, r;
        logic [1:0] op;
        logic [8:0] len;
        for (int i = 0; i < 256; i++) prog_data[i] = 8'(i);

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_op_ready), 32'd1);
        check("rst_done", 32'(o_op_done), 32'd0);
        check("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
        check("rst_status", 32'(o_status), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_READ,    24'h001000, 9'd4,   0);
        run_op(OP_ERASE,   24'h020000, 9'd0,   3);
        run_op(OP_PROGRAM, 24'h000100, 9'd256, 0);
        run_op(OP_ERASE,   24'h030000, 9'd0,   1000);
        run_op(OP_READ,    24'h000040, 9'd0,   0);
        run_op(OP_PROGRAM, 24'h000200, 9'd300, 0);
        run_op(OP_READ_ID, 24'h000000, 9'd3,   0);

        // Reset while waiting between polls of a stuck erase
        cs = cmd_log.size();
        op_start_cmd = cs;
        busy_n = 1000;
        issue(OP_ERASE, 24'h040000, 9'd0, c0);
        t = 0; nr = 0;
        while (nr < 2 && t < 5000) begin
            @(negedge clk); t++;
            nr = 0;
            for (int i = cs; i < cmd_log.size(); i++) if (cmd_log[i].opc == CMD_RDSR) nr++;
        end
        check("reset_setup_polls", 32'(nr), 32'd2);
        repeat (CS_GAP + 3 + POLL_GAP / 2) @(negedge clk);
        ds = done_q.size();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_ready", 32'(o_op_ready), 32'd1);
        check("mid_rst_done", 32'(o_op_done), 32'd0);
        check("mid_rst_err", 32'(o_op_err), 32'd0);
        check("mid_rst_status", 32'(o_status), 32'd0);
        check("mid_rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
        check("mid_rst_cmd", 32'(o_cmd), 32'd0);
        check("mid_rst_addr", 32'(o_addr), 32'd0);
        check("mid_rst_size", 32'(o_byte_size), 32'd0);
        rst_n = 1'b1;
        cs = cmd_log.size();
        repeat (60) @(negedge clk);
        check("no_done_after_rst", 32'(done_q.size() - ds), 32'd0);
        check("no_cmd_after_rst", 32'(cmd_log.size() - cs), 32'd0);
        model_status = 8'h00;
        run_op(OP_READ, 24'h001000, 9'd4, 0);

        // Randomized requests
        for (int n = 0; n < 12; n++) begin
            op = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            if (r == 0)      len = 9'd0;
            else if (r == 1) len = 9'($urandom_range(257, 511));
            else if (r == 2) len = 9'd256;
            else             len = 9'($urandom_range(1, 40));
            run_op(op, 24'($urandom), len, $urandom_range(0, POLL_MAX));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
